// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and the rotating-priority pick used by the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Scan (last+1) upward with wrap; returns last when nothing is requesting.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// 3-to-8 one-hot decoder with enable; output is all zero when disabled.
module decoder_3_to_8 (
    input  logic       ena,
    input  logic [2:0] in,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (ena) out[in] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters; holds each grant until done, request drop
// or MAX_HOLD cycles, always leaving one idle cycle between grants.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD);

    arb_state_t        state;
    logic [IDX_W-1:0]  last;
    logic [HOLD_W-1:0] hold_cnt;

    logic              hold_limit;
    logic              release_now;
    logic              forced;
    logic [IDX_W-1:0]  next_idx;

    always_comb begin
        hold_limit  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        release_now = done || !req[gnt_idx] || hold_limit;
        // A pulse only when the limit alone ends the grant.
        forced      = hold_limit && !done && req[gnt_idx];
        next_idx    = rr_pick(req, last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            last     <= IDX_W'(N_REQ - 1);
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (ena && |req) begin
                        gnt_idx  <= next_idx;
                        hold_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        last     <= gnt_idx;
                        hold_cnt <= '0;
                        timeout  <= forced;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        timeout  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_valid = (state == BUSY);

    decoder_3_to_8 u_dec (
        .ena (gnt_valid),
        .in  (gnt_idx),
        .out (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus random traffic,
// all compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: grant bookkeeping in plain integers
    int m_busy, m_idx, m_last, m_len, m_to;

    function automatic int model_pick(input logic [7:0] r, input int last_i);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last_i + k) % 8]) return (last_i + k) % 8;
        end
        return last_i;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_idx <= 0; m_last <= 7; m_len <= 0; m_to <= 0;
        end else if (m_busy == 0) begin
            m_to <= 0;
            if (ena && req != 8'h00) begin
                m_busy <= 1;
                m_idx  <= model_pick(req, m_last);
                m_len  <= 1;
            end
        end else if (done || !req[m_idx] || m_len == MAX_HOLD) begin
            m_busy <= 0;
            m_last <= m_idx;
            m_to   <= (m_len == MAX_HOLD && !done && req[m_idx]) ? 1 : 0;
        end else begin
            m_len <= m_len + 1;
            m_to  <= 0;
        end
    end

    always @(negedge clk) begin
        chk("model_gnt", gnt, m_busy != 0 ? (32'd1 << m_idx) : 32'd0);
        chk("model_gnt_idx", gnt_idx, m_idx);
        chk("model_gnt_valid", gnt_valid, m_busy);
        chk("model_timeout", timeout, m_to);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int cnt;

    initial begin
        rst = 1'b0; ena = 1'b1; req = 8'hFF; done = 1'b0;
        // 1: reset holds everything low, then first grant goes to requester 0
        tick();
        chk("rst_gnt", gnt, 0); chk("rst_idx", gnt_idx, 0);
        chk("rst_valid", gnt_valid, 0); chk("rst_timeout", timeout, 0);
        rst = 1'b1; req = 8'h01;
        tick();
        chk("first_gnt", gnt, 8'h01); chk("first_valid", gnt_valid, 1);

        // 2: full rotation with a dead cycle between grants
        req = 8'hFF; done = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rot_dead", gnt, 0);
            done = 1'b0;
            tick();
            chk("rot_idx", gnt_idx, k % 8);
            chk("rot_valid", gnt_valid, 1);
            done = 1'b1;
        end

        // 3: last=2, then req 7 and 0 -> 7 then 0
        req = 8'h04;
        tick(); done = 1'b0;
        tick(); chk("skip_idx2", gnt_idx, 2);
        req = 8'h81;
        tick(); chk("skip_dead", gnt, 0);
        tick(); chk("wrap_idx7", gnt_idx, 7);
        done = 1'b1;
        tick(); done = 1'b0;
        tick(); chk("wrap_idx0", gnt_idx, 0);

        // 4: forced release after MAX_HOLD cycles
        req = 8'h08;
        tick();
        tick(); chk("to_gnt", gnt, 8'h08);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt != 8'h08) break;
            cnt++;
        end
        chk("to_len", cnt, MAX_HOLD);
        chk("to_pulse", timeout, 1);
        chk("to_dead", gnt, 0);
        tick();
        chk("to_regrant", gnt, 8'h08); chk("to_pulse_end", timeout, 0);

        // 5: done coincident with the limit, then a request drop
        repeat (MAX_HOLD - 1) tick();
        done = 1'b1;
        tick(); chk("coin_gnt", gnt, 0); chk("coin_timeout", timeout, 0);
        done = 1'b0;
        tick(); chk("coin_regrant", gnt, 8'h08);
        tick(); req = 8'h00;
        tick(); chk("drop_gnt", gnt, 0); chk("drop_timeout", timeout, 0);

        // 6: asynchronous reset mid-grant, then ena gating
        req = 8'h20;
        tick(); chk("mid_idx5", gnt_idx, 5);
        @(posedge clk); #3 rst = 1'b0;
        #1 chk("async_gnt", gnt, 0); chk("async_valid", gnt_valid, 0);
        tick(); rst = 1'b1; req = 8'hFF;
        tick(); chk("post_rst_idx", gnt_idx, 0); chk("post_rst_valid", gnt_valid, 1);
        ena = 1'b0;
        repeat (3) begin tick(); chk("ena0_hold", gnt, 8'h01); end
        done = 1'b1;
        tick(); done = 1'b0;
        repeat (3) begin chk("ena0_nogrant", gnt, 0); tick(); end
        ena = 1'b1;
        tick(); chk("ena1_idx", gnt_idx, 1);

        // Random traffic, checked only by the model comparison
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 8'h00;
                    1: req = 8'h01 << $urandom_range(0, 7);
                    default: req = 8'($urandom());
                endcase
            end
            done = ($urandom_range(0, 19) == 0);
            ena  = ($urandom_range(0, 7) != 0);
            rst  = ($urandom_range(0, 499) != 0);
        end
        rst = 1'b1;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
